// File: rtl/pb_uart_sequencer.sv
// ----------------------------------------------------------------------------
// pb_uart_sequencer
//
// Bus master for the port-mapped UART register block (pb_uart_regs). It
// replaces a PicoBlaze: after reset it programs the clock divider and the
// control register, then serves a TX byte stream (valid/ready) and delivers
// RX bytes when the register block raises its interrupt. RX has strict
// priority when the bus is idle, but a TX that has started status polling
// always finishes first.
//
// Bus outputs are registered. They are loaded from the next FSM state, so
// whatever the bus shows in a cycle belongs to the state held in that cycle.
// The one exception is the first cycle after reset, when the bus is still
// parked while the FSM is already in StInitDivL.
//
// Optional feature: define PB_UART_SEQ_TIMEOUT_EN to bound the tx_full poll
// loop at TIMEOUT_POLLS results. A timed-out byte is consumed (tx_ready
// pulses) without being written, and o_tx_error sets until reset.
//
// Ports:
//   clk              clock
//   reset            asynchronous active-low reset
//   o_port_id        register address to the UART register block
//   o_write_data     data to register block data_in
//   i_read_data      register block data_out (one cycle after the address)
//   o_read_strobe    read qualifier
//   o_write_strobe   write qualifier
//   i_uart_interrupt rx_data_present from the register block
//   o_init_done      high once the init writes are complete
//   i_tx_valid       client TX byte valid
//   i_tx_data        client TX byte
//   o_tx_ready       one-cycle pulse: TX byte accepted
//   o_rx_valid       one-cycle pulse: o_rx_data valid
//   o_rx_data        received byte, held until the next o_rx_valid
//   o_tx_error       sticky poll timeout flag (0 without the optional feature)
// ----------------------------------------------------------------------------
module pb_uart_sequencer #(
    parameter logic [7:0]  BASE_ADDRESS  = 8'h00,
    parameter logic [15:0] CLOCK_DIVIDE  = 16'd27,
    parameter logic [7:0]  CONTROL_INIT  = 8'h01,
    parameter logic [7:0]  PARK_OFFSET   = 8'h07,
    parameter logic [7:0]  TIMEOUT_POLLS = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] o_port_id,
    output logic [7:0] o_write_data,
    input  logic [7:0] i_read_data,
    output logic       o_read_strobe,
    output logic       o_write_strobe,
    input  logic       i_uart_interrupt,
    output logic       o_init_done,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_ready,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_data,
    output logic       o_tx_error
);

    localparam logic [7:0] ADDR_DATA = BASE_ADDRESS;
    localparam logic [7:0] ADDR_CTRL = BASE_ADDRESS + 8'd1;
    localparam logic [7:0] ADDR_STAT = BASE_ADDRESS + 8'd2;
    localparam logic [7:0] ADDR_DIVL = BASE_ADDRESS + 8'd5;
    localparam logic [7:0] ADDR_DIVH = BASE_ADDRESS + 8'd6;
    localparam logic [7:0] ADDR_PARK = BASE_ADDRESS + PARK_OFFSET;

    typedef enum logic [3:0] {
        StInitDivL,
        StInitDivH,
        StInitCtrl,
        StIdle,
        StTxStatA,
        StTxStatS,
        StTxWr,
        StRxStatA,
        StRxStatS,
        StRxDataA,
        StRxDataS
    } state_t;

    state_t     r_state;
    state_t     w_state_d;
    logic       w_timeout;

    logic [7:0] r_port_id;
    logic [7:0] r_write_data;
    logic       r_read_strobe;
    logic       r_write_strobe;
    logic       r_init_done;
    logic       r_tx_ready;
    logic       r_rx_valid;
    logic [7:0] r_rx_data;

    logic [7:0] w_port_id;
    logic [7:0] w_write_data;
    logic       w_read_strobe;
    logic       w_write_strobe;

`ifdef PB_UART_SEQ_TIMEOUT_EN
    logic [7:0] r_poll_cnt;
    logic [7:0] w_poll_cnt_d;
    logic       r_tx_error;
`endif

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StInitDivL;
        end else begin
            r_state <= w_state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state;
        w_timeout = 1'b0;
`ifdef PB_UART_SEQ_TIMEOUT_EN
        w_poll_cnt_d = r_poll_cnt;
`endif
        case (r_state)
            // The bus is still parked in the first cycle after reset; hold
            // here until the divider-low write is actually on the bus.
            StInitDivL: if (r_write_strobe) w_state_d = StInitDivH;
            StInitDivH: w_state_d = StInitCtrl;
            StInitCtrl: w_state_d = StIdle;
            StIdle: begin
                if (i_uart_interrupt) begin
                    w_state_d = StRxStatA;
                end else if (i_tx_valid) begin
                    w_state_d = StTxStatA;
`ifdef PB_UART_SEQ_TIMEOUT_EN
                    w_poll_cnt_d = 8'd0;
`endif
                end
            end
            StTxStatA: w_state_d = StTxStatS;
            StTxStatS: begin
                if (i_read_data[5]) begin
`ifdef PB_UART_SEQ_TIMEOUT_EN
                    w_poll_cnt_d = r_poll_cnt + 8'd1;
                    // Widened compare so a limit of 0 or 255 cannot wrap.
                    if ({1'b0, r_poll_cnt} + 9'd1 >= {1'b0, TIMEOUT_POLLS}) begin
                        w_state_d = StIdle;
                        w_timeout = 1'b1;
                    end else begin
                        w_state_d = StTxStatA;
                    end
`else
                    w_state_d = StTxStatA;
`endif
                end else begin
                    w_state_d = StTxWr;
                end
            end
            StTxWr:    w_state_d = StIdle;
            StRxStatA: w_state_d = StRxStatS;
            StRxStatS: w_state_d = i_read_data[0] ? StRxDataA : StIdle;
            StRxDataA: w_state_d = StRxDataS;
            StRxDataS: w_state_d = StIdle;
            default:   w_state_d = StInitDivL;
        endcase
    end

    // ------------------------------------------------------------------------
    // Bus action of the state being entered. Read sample cycles and idle park
    // the port, so the data address is never held for two cycles in a row.
    // ------------------------------------------------------------------------
    always_comb begin
        w_port_id      = ADDR_PARK;
        w_write_data   = r_write_data;
        w_read_strobe  = 1'b0;
        w_write_strobe = 1'b0;
        case (w_state_d)
            StInitDivL: begin
                w_port_id      = ADDR_DIVL;
                w_write_data   = CLOCK_DIVIDE[7:0];
                w_write_strobe = 1'b1;
            end
            StInitDivH: begin
                w_port_id      = ADDR_DIVH;
                w_write_data   = CLOCK_DIVIDE[15:8];
                w_write_strobe = 1'b1;
            end
            StInitCtrl: begin
                w_port_id      = ADDR_CTRL;
                w_write_data   = CONTROL_INIT;
                w_write_strobe = 1'b1;
            end
            StTxStatA, StRxStatA: begin
                w_port_id     = ADDR_STAT;
                w_read_strobe = 1'b1;
            end
            StRxDataA: begin
                w_port_id     = ADDR_DATA;
                w_read_strobe = 1'b1;
            end
            StTxWr: begin
                w_port_id      = ADDR_DATA;
                w_write_data   = i_tx_data;
                w_write_strobe = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_port_id      <= ADDR_PARK;
            r_write_data   <= 8'h00;
            r_read_strobe  <= 1'b0;
            r_write_strobe <= 1'b0;
            r_init_done    <= 1'b0;
            r_tx_ready     <= 1'b0;
            r_rx_valid     <= 1'b0;
            r_rx_data      <= 8'h00;
        end else begin
            r_port_id      <= w_port_id;
            r_write_data   <= w_write_data;
            r_read_strobe  <= w_read_strobe;
            r_write_strobe <= w_write_strobe;
            r_tx_ready     <= (w_state_d == StTxWr) || w_timeout;
            r_rx_valid     <= (r_state == StRxDataS);
            if (r_state == StRxDataS) begin
                r_rx_data <= i_read_data;
            end
            // First entry into idle marks the end of init; sticky until reset.
            if (w_state_d == StIdle) begin
                r_init_done <= 1'b1;
            end
        end
    end

`ifdef PB_UART_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_poll_cnt <= 8'd0;
            r_tx_error <= 1'b0;
        end else begin
            r_poll_cnt <= w_poll_cnt_d;
            if (w_timeout) begin
                r_tx_error <= 1'b1;
            end
        end
    end

    assign o_tx_error = r_tx_error;
`else
    // Polling is unbounded; the limit only matters with the timeout enabled.
    logic w_unused_timeout_polls;
    assign w_unused_timeout_polls = ^TIMEOUT_POLLS;
    assign o_tx_error = 1'b0;
`endif

    assign o_port_id      = r_port_id;
    assign o_write_data   = r_write_data;
    assign o_read_strobe  = r_read_strobe;
    assign o_write_strobe = r_write_strobe;
    assign o_init_done    = r_init_done;
    assign o_tx_ready     = r_tx_ready;
    assign o_rx_valid     = r_rx_valid;
    assign o_rx_data      = r_rx_data;

endmodule

// File: tb/tb_pb_uart_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pb_uart_sequencer
//
// Self-checking bench for pb_uart_sequencer. A small behavioural stand-in for
// the UART register block answers status/data reads (registered, one cycle
// latency) and raises the interrupt while its RX FIFO holds data. A passive
// monitor logs bus writes, tx_ready/rx_valid pulses and data-address runs.
// Expected results come from transaction-level rules: latency 3 + 2*polls
// for TX, 5 for RX, one write per TX byte, FIFO order for RX.
// ----------------------------------------------------------------------------
module tb_pb_uart_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] o_port_id;
    logic [7:0] o_write_data;
    logic [7:0] i_read_data = 8'h00;
    logic       o_read_strobe;
    logic       o_write_strobe;
    logic       i_uart_interrupt = 1'b0;
    logic       o_init_done;
    logic       i_tx_valid = 1'b0;
    logic [7:0] i_tx_data = 8'h00;
    logic       o_tx_ready;
    logic       o_rx_valid;
    logic [7:0] o_rx_data;
    logic       o_tx_error;

    always #5 clk = ~clk;

    pb_uart_sequencer #(
        .TIMEOUT_POLLS(8'd4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .o_port_id       (o_port_id),
        .o_write_data    (o_write_data),
        .i_read_data     (i_read_data),
        .o_read_strobe   (o_read_strobe),
        .o_write_strobe  (o_write_strobe),
        .i_uart_interrupt(i_uart_interrupt),
        .o_init_done     (o_init_done),
        .i_tx_valid      (i_tx_valid),
        .i_tx_data       (i_tx_data),
        .o_tx_ready      (o_tx_ready),
        .o_rx_valid      (o_rx_valid),
        .o_rx_data       (o_rx_data),
        .o_tx_error      (o_tx_error)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Register block stand-in
    logic [7:0] rx_mem [256];
    int rx_wr = 0;
    int rx_rd = 0;
    int stat_reads = 0;
    int full_until = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_read_strobe && o_port_id == 8'h02) begin
            i_read_data <= {2'b00, (stat_reads < full_until), 4'b0000, (rx_wr != rx_rd)};
            stat_reads  <= stat_reads + 1;
        end else if (o_read_strobe && o_port_id == 8'h00) begin
            i_read_data <= rx_mem[rx_rd % 256];
            rx_rd       <= rx_rd + 1;
        end
        i_uart_interrupt <= (rx_wr != rx_rd + ((o_read_strobe && o_port_id == 8'h00) ? 1 : 0));
    end

    // Bus monitor
    logic [7:0] wr_addr [128];
    logic [7:0] wr_data [128];
    int         wr_cyc  [128];
    logic [7:0] rxv_data [128];
    int wr_cnt = 0;
    int ready_cnt = 0;
    int ready_cyc = -1;
    int rxv_cnt = 0;
    int rxv_cyc = -1;
    int port0_run = 0;
    int port0_max = 0;

    always @(negedge clk) begin
        if (o_write_strobe) begin
            wr_addr[wr_cnt % 128] <= o_port_id;
            wr_data[wr_cnt % 128] <= o_write_data;
            wr_cyc[wr_cnt % 128]  <= cyc;
            wr_cnt <= wr_cnt + 1;
        end
        if (o_tx_ready) begin
            ready_cnt <= ready_cnt + 1;
            ready_cyc <= cyc;
        end
        if (o_rx_valid) begin
            rxv_data[rxv_cnt % 128] <= o_rx_data;
            rxv_cnt <= rxv_cnt + 1;
            rxv_cyc <= cyc;
        end
        if (o_port_id == 8'h00) begin
            port0_run <= port0_run + 1;
            if (port0_run + 1 > port0_max) port0_max <= port0_run + 1;
        end else begin
            port0_run <= 0;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " port_id"}, o_port_id, 8'h07);
        check({tag, " write_data"}, o_write_data, 8'h00);
        check({tag, " strobes"}, {o_read_strobe, o_write_strobe}, 2'b00);
        check({tag, " init_done"}, o_init_done, 1'b0);
        check({tag, " tx_ready"}, o_tx_ready, 1'b0);
        check({tag, " rx_valid"}, o_rx_valid, 1'b0);
        check({tag, " rx_data"}, o_rx_data, 8'h00);
        check({tag, " tx_error"}, o_tx_error, 1'b0);
    endtask

    // Release reset and expect (5,1B),(6,00),(1,01) back to back, then
    // init_done one cycle after the last write with the port parked.
    task automatic release_and_check_init(input string tag);
        int w0;
        int tinit;
        w0 = wr_cnt;
        tinit = -1;
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (o_init_done && tinit < 0) tinit = cyc;
        end
        check({tag, " writes"}, wr_cnt - w0, 3);
        check({tag, " w0"}, {wr_addr[w0 % 128], wr_data[w0 % 128]}, 16'h051B);
        check({tag, " w1"}, {wr_addr[(w0 + 1) % 128], wr_data[(w0 + 1) % 128]}, 16'h0600);
        check({tag, " w2"}, {wr_addr[(w0 + 2) % 128], wr_data[(w0 + 2) % 128]}, 16'h0101);
        check({tag, " gap01"}, wr_cyc[(w0 + 1) % 128] - wr_cyc[w0 % 128], 1);
        check({tag, " gap12"}, wr_cyc[(w0 + 2) % 128] - wr_cyc[(w0 + 1) % 128], 1);
        check({tag, " init_done"}, tinit, wr_cyc[(w0 + 2) % 128] + 1);
        check({tag, " park"}, o_port_id, 8'h07);
    endtask

    task automatic wait_ready(input int r0, output int at);
        at = -1;
        for (int i = 0; i < 300; i++) begin
            if (ready_cnt != r0) begin
                at = ready_cyc;
                break;
            end
            tick(1);
        end
    endtask

    // One TX byte with nfull tx_full status results before the free one.
    task automatic do_tx(input string tag, input logic [7:0] b, input int nfull);
        int t0, at, w0, r0, s0;
        full_until = stat_reads + nfull;
        w0 = wr_cnt;
        r0 = ready_cnt;
        s0 = stat_reads;
        i_tx_data  = b;
        i_tx_valid = 1'b1;
        t0 = cyc;
        wait_ready(r0, at);
        i_tx_valid = 1'b0;
        tick(3);
        check({tag, " latency"}, at - t0, 3 + 2 * nfull);
        check({tag, " nwrites"}, wr_cnt - w0, 1);
        check({tag, " write"}, {wr_addr[w0 % 128], wr_data[w0 % 128]}, {8'h00, b});
        check({tag, " polls"}, stat_reads - s0, nfull + 1);
        check({tag, " nready"}, ready_cnt - r0, 1);
    endtask

    // Push n bytes into the FIFO at once and expect them back in order.
    task automatic do_rx(input string tag, input int n);
        logic [7:0] exp [4];
        int t0, v0;
        v0 = rxv_cnt;
        for (int k = 0; k < n; k++) begin
            exp[k] = 8'($urandom);
            rx_mem[(rx_wr + k) % 256] = exp[k];
        end
        rx_wr = rx_wr + n;
        t0 = cyc;
        for (int i = 0; i < 300 && rxv_cnt < v0 + n; i++) tick(1);
        if (n == 1) check({tag, " latency"}, rxv_cyc - t0, 6);
        tick(3);
        check({tag, " count"}, rxv_cnt - v0, n);
        for (int k = 0; k < n; k++) begin
            check({tag, " byte"}, rxv_data[(v0 + k) % 128], exp[k]);
        end
        check({tag, " held"}, o_rx_data, exp[n - 1]);
        check({tag, " port0 run"}, port0_max, 1);
    endtask

    initial begin
        int t, w0, r0, v0, found, at;
        logic [7:0] b1, b2;

        tick(3);
        check_reset_vals("reset");
        release_and_check_init("init");

        do_tx("tx41", 8'h41, 0);
        do_tx("tx_poll3", 8'($urandom), 3);
        for (int i = 0; i < 4; i++) begin
            do_tx("tx_rand", 8'($urandom), int'($urandom_range(0, 3)));
        end

        // Single byte 5A, then random bursts.
        rx_mem[rx_wr % 256] = 8'h5A;
        v0 = rxv_cnt;
        rx_wr = rx_wr + 1;
        t = cyc;
        for (int i = 0; i < 50 && rxv_cnt == v0; i++) tick(1);
        tick(1);
        check("rx5A latency", rxv_cyc - t, 6);
        check("rx5A data", o_rx_data, 8'h5A);
        check("rx5A pulse", rxv_cnt - v0, 1);
        check("rx5A port0 run", port0_max, 1);
        do_rx("rx1", 1);
        do_rx("rx3", 3);

        // Interrupt and tx_valid in the same idle cycle: RX first, then TX.
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        full_until = stat_reads;
        rx_mem[rx_wr % 256] = b1;
        rx_wr = rx_wr + 1;
        tick(1);
        t = cyc;
        w0 = wr_cnt;
        v0 = rxv_cnt;
        r0 = ready_cnt;
        i_tx_data  = b2;
        i_tx_valid = 1'b1;
        wait_ready(r0, at);
        i_tx_valid = 1'b0;
        tick(3);
        check("both rx cycle", rxv_cyc - t, 5);
        check("both rx data", rxv_data[v0 % 128], b1);
        check("both tx cycle", at - t, 8);
        check("both tx write", {wr_addr[w0 % 128], wr_data[w0 % 128]}, {8'h00, b2});
        check("both nwrites", wr_cnt - w0, 1);

`ifdef PB_UART_SEQ_TIMEOUT_EN
        full_until = stat_reads + 1000;
        w0 = wr_cnt;
        r0 = ready_cnt;
        v0 = stat_reads;
        i_tx_data  = 8'h77;
        i_tx_valid = 1'b1;
        t = cyc;
        wait_ready(r0, at);
        i_tx_valid = 1'b0;
        tick(3);
        check("tmo latency", at - t, 9);
        check("tmo nwrites", wr_cnt - w0, 0);
        check("tmo polls", stat_reads - v0, 4);
        check("tmo nready", ready_cnt - r0, 1);
        check("tmo error", o_tx_error, 1'b1);
        do_tx("tmo after", 8'($urandom), 1);
        check("tmo sticky", o_tx_error, 1'b1);
`else
        check("no tmo error", o_tx_error, 1'b0);
`endif

        // Reset while a TX sits in its status sample cycle.
        full_until = stat_reads + 1000;
        r0 = ready_cnt;
        i_tx_data  = 8'hC3;
        i_tx_valid = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick(1);
            if (o_read_strobe) found = 1;
        end
        check("mid found addr", found, 1);
        tick(1);
        reset = 1'b0;
        #1;
        check_reset_vals("mid reset");
        i_tx_valid = 1'b0;
        full_until = stat_reads;
        tick(2);
        w0 = wr_cnt;
        release_and_check_init("replay");
        check("mid no ready", ready_cnt - r0, 0);
        do_tx("post reset", 8'($urandom), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
